// File: rtl/controlador_hcsr04_pkg.sv
// Shared types and defaults for the HC-SR04 controller:
// FSM state encoding, timing defaults, counter-width helper.
`timescale 1ns/1ps
package controlador_hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIGGER   = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int TICKS_PER_US_D = 1;
  localparam int TRIGGER_US_D   = 10;
  localparam int US_PER_CM_D    = 58;
  localparam int TIMEOUT_US_D   = 30000;
  localparam int DIST_W_D       = 9;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/controlador_hcsr04_gerador_tick.sv
// Microsecond tick: 1-cycle pulse every TICKS_PER_US clocks.
// Ports: clock, reset (async low), clear (restart phase), tick.
`timescale 1ns/1ps
module gerador_tick
  import controlador_hcsr04_pkg::*;
#(
  parameter int TICKS_PER_US = TICKS_PER_US_D
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_w(TICKS_PER_US);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_US - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/controlador_hcsr04.sv
// HC-SR04 initiator: trigger pulse, echo timing, us->cm.
// Ports: clock, reset(async low), medir, echo -> trigger,
// distancia, pronto, erro, ocupado.
`timescale 1ns/1ps
module controlador_hcsr04
  import controlador_hcsr04_pkg::*;
#(
  parameter int TICKS_PER_US = TICKS_PER_US_D,
  parameter int TRIGGER_US   = TRIGGER_US_D,
  parameter int US_PER_CM    = US_PER_CM_D,
  parameter int TIMEOUT_US   = TIMEOUT_US_D,
  parameter int DIST_W       = DIST_W_D
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              medir,
  input  logic              echo,
  output logic              trigger,
  output logic [DIST_W-1:0] distancia,
  output logic              pronto,
  output logic              erro,
  output logic              ocupado
);

  localparam int TMAX = (TIMEOUT_US > TRIGGER_US) ?
                        TIMEOUT_US : TRIGGER_US;
  localparam int TW = cnt_w(TMAX);
  localparam int SW = cnt_w(US_PER_CM);

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIGGER_US - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_US - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(US_PER_CM - 1);
  localparam logic [SW-1:0] SUB_HALF  = SW'(US_PER_CM / 2);
  localparam logic [DIST_W-1:0] CM_MAX = '1;

  state_t state, state_n;

  logic echo_m, echo_s, echo_d;
  logic rise, fall;
  logic tick, clear, timed;

  logic [TW-1:0]     tmr;
  logic [SW-1:0]     sub;
  logic [DIST_W-1:0] cm, cm_rnd;

  logic              ld;
  logic [DIST_W-1:0] dist_n;
  logic              erro_n;

  // echo is asynchronous: two flops, then one more for edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign rise = echo_s & ~echo_d;
  assign fall = ~echo_s & echo_d;

  // restart the us phase on every state change
  assign clear = (state_n != state);

  gerador_tick #(
    .TICKS_PER_US(TICKS_PER_US)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  assign timed = (state == TRIGGER) ||
                 (state == WAIT_ECHO) ||
                 (state == MEASURE);

  // half-up rounding of the leftover microseconds
  assign cm_rnd = (sub >= SUB_HALF && cm != CM_MAX) ?
                  cm + DIST_W'(1) : cm;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    ld      = 1'b0;
    dist_n  = distancia;
    erro_n  = erro;
    unique case (state)
      IDLE: begin
        if (medir) state_n = TRIGGER;
      end
      TRIGGER: begin
        if (tick && tmr == TRIG_LAST) state_n = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        if (rise) begin
          state_n = MEASURE;
        end else if (tick && tmr == TMO_LAST) begin
          state_n = DONE;
          ld      = 1'b1;
          dist_n  = CM_MAX;
          erro_n  = 1'b1;
        end
      end
      MEASURE: begin
        if (fall) begin
          state_n = DONE;
          ld      = 1'b1;
          dist_n  = cm_rnd;
          erro_n  = 1'b0;
        end else if (tick && tmr == TMO_LAST) begin
          state_n = DONE;
          ld      = 1'b1;
          dist_n  = CM_MAX;
          erro_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmr <= '0;
    end else if (clear) begin
      tmr <= '0;
    end else if (tick && timed) begin
      tmr <= tmr + TW'(1);
    end
  end

  // sub counts us within one cm; cm saturates
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sub <= '0;
      cm  <= '0;
    end else if (state == WAIT_ECHO && state_n == MEASURE) begin
      sub <= '0;
      cm  <= '0;
    end else if (state == MEASURE && state_n == MEASURE && tick) begin
      if (sub == SUB_LAST) begin
        sub <= '0;
        if (cm != CM_MAX) cm <= cm + DIST_W'(1);
      end else begin
        sub <= sub + SW'(1);
      end
    end
  end

  // result lands on the edge into DONE, together with pronto
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      distancia <= '0;
      erro      <= 1'b0;
    end else if (ld) begin
      distancia <= dist_n;
      erro      <= erro_n;
    end
  end

  assign trigger = (state == TRIGGER);
  assign pronto  = (state == DONE);
  assign ocupado = (state != IDLE);

endmodule

// File: tb/tb_controlador_hcsr04.sv
// Bench for controlador_hcsr04 at 1 MHz with an inline echo mock.
// Model queue of expected completions checked every cycle.
`timescale 1ns/1ps
module tb_controlador_hcsr04;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       medir = 1'b0;
  logic       echo  = 1'b0;
  logic       trigger;
  logic [8:0] distancia;
  logic       pronto;
  logic       erro;
  logic       ocupado;

  controlador_hcsr04 dut (
    .clock    (clock),
    .reset    (reset),
    .medir    (medir),
    .echo     (echo),
    .trigger  (trigger),
    .distancia(distancia),
    .pronto   (pronto),
    .erro     (erro),
    .ocupado  (ocupado)
  );

  always #500 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int d;
    int e;
    int cy;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  int   last_d = 0;
  int   last_e = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // echo width w us is counted as w-1 whole us; half-up to cm
  function automatic int model_cm(input int w);
    int c;
    int d;
    c = w - 1;
    d = c / 58 + (((c % 58) >= 29) ? 1 : 0);
    if (d > 511) d = 511;
    return d;
  endfunction

  always @(negedge clock) begin : cmp
    exp_t e;
    if (chk_en) begin
      if (pronto) begin
        check("pronto_expected", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("distancia", int'(distancia), e.d);
          check("erro", int'(erro), e.e);
          check("pronto_cycle", cyc, e.cy);
          last_d = e.d;
          last_e = e.e;
        end
      end else begin
        check("hold_distancia", int'(distancia), last_d);
        check("hold_erro", int'(erro), last_e);
      end
    end
  end

  task automatic run_meas(input int w, input bit repulse,
                          input int lit);
    int   hi;
    int   t;
    int   f;
    int   n;
    exp_t e;
    medir = 1'b1;
    step();
    medir = 1'b0;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      if (trigger) begin
        hi++;
        check("ocupado_trigger", int'(ocupado), 1);
      end else if (hi > 0) begin
        break;
      end
      step();
    end
    check("trigger_width", hi, 10);
    t = cyc;
    if (w < 0) begin
      e = '{511, 1, t + 30000};
      q.push_back(e);
    end else begin
      repeat (5) begin
        check("ocupado_wait", int'(ocupado), 1);
        step();
      end
      echo = 1'b1;
      for (int k = 0; k < w; k++) begin
        medir = (repulse && k == w / 2);
        step();
      end
      medir = 1'b0;
      echo  = 1'b0;
      f = cyc;
      e = '{model_cm(w), 0, f + 3};
      q.push_back(e);
    end
    n = 0;
    while (q.size() != 0 && n < 31000) begin
      step();
      n++;
    end
    check("pronto_arrived", int'(q.size()), 0);
    q.delete();
    step();
    step();
    check("ocupado_idle", int'(ocupado), 0);
    if (lit >= 0) check("distancia_literal", int'(distancia), lit);
    if (repulse) begin
      hi = 0;
      for (int k = 0; k < 20; k++) begin
        if (trigger) hi++;
        step();
      end
      check("no_retrigger", hi, 0);
    end
  endtask

  initial begin
    #(200000 * 1000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int wid[4];
    int lit[4];
    int n;
    wid = '{58, 348, 580, 812};
    lit = '{1, 6, 10, 14};

    medir = 1'b1;
    repeat (3) step();
    check("rst_trigger", int'(trigger), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_pronto", int'(pronto), 0);
    check("rst_distancia", int'(distancia), 0);
    check("rst_erro", int'(erro), 0);
    medir = 1'b0;
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    step();

    for (int i = 0; i < 4; i++) run_meas(wid[i], 1'b0, lit[i]);

    run_meas(-1, 1'b0, 511);
    check("erro_sticky", int'(erro), 1);

    run_meas(29, 1'b0, 0);
    check("erro_cleared", int'(erro), 0);
    run_meas(30, 1'b0, 1);

    run_meas(400, 1'b1, 7);

    run_meas(30, 1'b0, 1);
    medir = 1'b1;
    step();
    medir = 1'b0;
    n = 0;
    while (trigger && n < 40) begin
      step();
      n++;
    end
    repeat (5) step();
    echo = 1'b1;
    repeat (100) step();
    check("pre_reset_ocupado", int'(ocupado), 1);
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("async_trigger", int'(trigger), 0);
    check("async_ocupado", int'(ocupado), 0);
    check("async_pronto", int'(pronto), 0);
    check("async_distancia", int'(distancia), 0);
    check("async_erro", int'(erro), 0);
    step();
    echo = 1'b0;
    step();
    step();
    reset = 1'b1;
    q.delete();
    last_d = 0;
    last_e = 0;
    step();
    chk_en = 1'b1;
    step();
    run_meas(58, 1'b0, 1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
